// File: rtl/hazard_sequencer.sv
// hazard_sequencer: load-use / redirect / dmem-wait stall and flush sequencer for the 5-stage core.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_sequencer #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ifid_rs1,
   input  logic [4:0]  ifid_rs2,
   input  logic        ifid_use_rs1,
   input  logic        ifid_use_rs2,
   input  logic [4:0]  idex_rd,
   input  logic        idex_mem_read,
   input  logic        ex_branch_taken,
   input  logic        ex_jal,
   input  logic        ex_jalr,
   input  logic        dmem_busy,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        ctrl_bubble,
   output logic        pipe_freeze,
   output logic        pc_redirect,
   output logic [1:0]  state_o,
   output logic [31:0] stall_count,
   output logic [31:0] flush_count
);
   typedef enum logic [1:0] {RUN = 2'd0, LDSTALL = 2'd1, FLUSH = 2'd2, MEMWAIT = 2'd3} state_t;
   localparam logic [2:0] LS_M1 = 3'(LOAD_STALL_CYCLES - 1);
   localparam logic [2:0] FC_M1 = 3'(FLUSH_CYCLES - 1);
   if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 7) begin : g_bad_ls
      $error("LOAD_STALL_CYCLES must be in 1..7");
   end
   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_fc
      $error("FLUSH_CYCLES must be in 1..7");
   end
   state_t state, state_nx;
   logic [2:0] cnt, cnt_nx;
   logic lu, rd, stall, redir, fl;
   assign lu = idex_mem_read && idex_rd != 5'd0 &&
               ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
   assign rd = ex_branch_taken | ex_jal | ex_jalr;
   // MEMWAIT with dmem_busy low falls through to the RUN evaluation
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      stall    = 1'b0;
      redir    = 1'b0;
      fl       = 1'b0;
      if (dmem_busy) begin
         state_nx = (state == RUN) ? MEMWAIT : state;
      end else if (rd) begin
         redir    = 1'b1;
         state_nx = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
         cnt_nx   = FC_M1;
      end else if (state == LDSTALL) begin
         stall    = 1'b1;
         state_nx = (cnt == 3'd1) ? RUN : LDSTALL;
         cnt_nx   = cnt - 3'd1;
      end else if (state == FLUSH) begin
         fl       = 1'b1;
         state_nx = (cnt == 3'd1) ? RUN : FLUSH;
         cnt_nx   = cnt - 3'd1;
      end else if (lu) begin
         stall    = 1'b1;
         state_nx = (LOAD_STALL_CYCLES > 1) ? LDSTALL : RUN;
         cnt_nx   = LS_M1;
      end else begin
         state_nx = RUN;
      end
   end
   assign pipe_freeze = reset & dmem_busy;
   assign pc_write    = reset & ~dmem_busy & ~stall;
   assign ifid_write  = pc_write;
   assign ifid_flush  = ~reset | redir | fl;
   assign ctrl_bubble = ~reset | redir | fl | stall;
   assign pc_redirect = reset & redir;
   assign state_o     = state;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] s_cnt, f_cnt;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_cnt <= '0;
         f_cnt <= '0;
      end else begin
         if (stall && s_cnt != '1) s_cnt <= s_cnt + 32'd1;
         if ((redir || fl) && f_cnt != '1) f_cnt <= f_cnt + 32'd1;
      end
   end
   assign stall_count = s_cnt;
   assign flush_count = f_cnt;
`else
   assign stall_count = '0;
   assign flush_count = '0;
`endif
endmodule
